// File: rtl/eth_axis_tx_width_conv.sv
// eth_axis_tx_width_conv: S_BYTES-wide AXIS words crossed through a dual-clock FIFO and serialised to bytes.
// Define ETH_TX_PAD_EN to zero-pad frames shorter than MIN_FRAME_BYTES.
module udma_dc_fifo #(
   parameter int DATA_WIDTH   = 32,
   parameter int BUFFER_DEPTH = 8
) (
   input  logic                  src_clk_i,
   input  logic                  src_rstn_i,
   input  logic [DATA_WIDTH-1:0] src_data_i,
   input  logic                  src_valid_i,
   output logic                  src_ready_o,
   input  logic                  dst_clk_i,
   input  logic                  dst_rstn_i,
   output logic [DATA_WIDTH-1:0] dst_data_o,
   output logic                  dst_valid_o,
   input  logic                  dst_ready_i
);
   localparam int AW = $clog2(BUFFER_DEPTH);
   logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
   logic [AW:0] wbin_q, wgray_q, rbin_q, rgray_q, wg1_q, wg2_q, rg1_q, rg2_q;
   logic [AW:0] wbin_d, rbin_d;
   logic        wr, rd;
   assign wbin_d      = wbin_q + (AW+1)'(1);
   assign rbin_d      = rbin_q + (AW+1)'(1);
   // Gray pointers: full when the two MSBs differ and the rest match.
   assign src_ready_o = wgray_q != {~rg2_q[AW:AW-1], rg2_q[AW-2:0]};
   assign dst_valid_o = rgray_q != wg2_q;
   assign dst_data_o  = mem_q[rbin_q[AW-1:0]];
   assign wr          = src_valid_i & src_ready_o;
   assign rd          = dst_valid_o & dst_ready_i;
   always_ff @(posedge src_clk_i)
      if (wr) mem_q[wbin_q[AW-1:0]] <= src_data_i;
   always_ff @(posedge src_clk_i or negedge src_rstn_i)
      if (!src_rstn_i) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         rg1_q   <= '0;
         rg2_q   <= '0;
      end else begin
         rg1_q <= rgray_q;
         rg2_q <= rg1_q;
         if (wr) begin
            wbin_q  <= wbin_d;
            wgray_q <= wbin_d ^ (wbin_d >> 1);
         end
      end
   always_ff @(posedge dst_clk_i or negedge dst_rstn_i)
      if (!dst_rstn_i) begin
         rbin_q  <= '0;
         rgray_q <= '0;
         wg1_q   <= '0;
         wg2_q   <= '0;
      end else begin
         wg1_q <= wgray_q;
         wg2_q <= wg1_q;
         if (rd) begin
            rbin_q  <= rbin_d;
            rgray_q <= rbin_d ^ (rbin_d >> 1);
         end
      end
endmodule

module eth_axis_tx_width_conv #(
   parameter int S_BYTES         = 4,
   parameter int FIFO_DEPTH      = 32,
   parameter int MIN_FRAME_BYTES = 60
) (
   input  logic                       m_clk_i,
   input  logic                       m_rstn_i,
   input  logic                       s_clk_i,
   input  logic                       s_rstn_i,
   input  logic [8*S_BYTES-1:0]       s_axis_tdata,
   input  logic [$clog2(S_BYTES)-1:0] s_axis_byte_count,
   input  logic                       s_axis_tvalid,
   input  logic                       s_axis_tuser,
   input  logic                       s_axis_tlast,
   output logic                       s_axis_tready,
   output logic [7:0]                 m_axis_tdata,
   output logic                       m_axis_tvalid,
   output logic                       m_axis_tuser,
   output logic                       m_axis_tlast,
   input  logic                       m_axis_tready,
   output logic                       frame_done_o,
   output logic [15:0]                frame_len_o,
   output logic                       tx_underrun_o
);
   localparam int LW = $clog2(S_BYTES);
   localparam int FW = 8*S_BYTES + LW + 2;
`ifdef ETH_TX_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, DATA, PAD} state_t;
   state_t               state_q, state_d;
   logic [LW-1:0]        lane_q, last_lane, h_bc;
   logic [15:0]          byte_cnt_q, byte_cnt_d, cnt_inc;
   logic                 uflow_q, done_q, urun_q;
   logic [15:0]          len_q;
   logic [FW-1:0]        h_word;
   logic [8*S_BYTES-1:0] h_data;
   logic                 h_valid, h_last, h_user;
   logic                 in_pad, short_frm, pad_end, fin_data, hs, pop, fin;
   udma_dc_fifo #(.DATA_WIDTH(FW), .BUFFER_DEPTH(FIFO_DEPTH)) u_fifo (
      .src_clk_i  (s_clk_i),
      .src_rstn_i (s_rstn_i),
      .src_data_i ({s_axis_tuser, s_axis_tlast, s_axis_byte_count, s_axis_tdata}),
      .src_valid_i(s_axis_tvalid),
      .src_ready_o(s_axis_tready),
      .dst_clk_i  (m_clk_i),
      .dst_rstn_i (m_rstn_i),
      .dst_data_o (h_word),
      .dst_valid_o(h_valid),
      .dst_ready_i(pop)
   );
   assign {h_user, h_last, h_bc, h_data} = h_word;
   assign cnt_inc   = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 16'd1;
   assign in_pad    = PAD_EN && state_q == PAD;
   assign short_frm = PAD_EN && ({1'b0, byte_cnt_q} + 17'd1 < 17'(MIN_FRAME_BYTES));
   assign pad_end   = {1'b0, byte_cnt_q} + 17'd1 == 17'(MIN_FRAME_BYTES);
   assign last_lane = h_last ? h_bc : LW'(S_BYTES-1);
   assign fin_data  = !in_pad && h_valid && h_last && lane_q == h_bc;
   assign m_axis_tvalid = in_pad | h_valid;
   assign m_axis_tdata  = (!in_pad && h_valid) ? h_data[lane_q*8 +: 8] : 8'h00;
   assign m_axis_tuser  = !in_pad && h_valid && h_user;
   assign m_axis_tlast  = in_pad ? pad_end : fin_data && !short_frm;
   assign hs            = m_axis_tvalid && m_axis_tready;
   assign pop           = hs && !in_pad && lane_q == last_lane;
   assign fin           = hs && m_axis_tlast;
   assign frame_done_o  = done_q;
   assign frame_len_o   = len_q;
   assign tx_underrun_o = urun_q;
   assign byte_cnt_d    = !hs ? byte_cnt_q : fin ? 16'd0 : cnt_inc;
   // A short frame's final data byte hands over to PAD instead of closing the frame.
   always_comb
      state_d = fin ? IDLE : (hs && fin_data) ? PAD : (state_q == IDLE && h_valid) ? DATA : state_q;
   always_ff @(posedge m_clk_i or negedge m_rstn_i)
      if (!m_rstn_i) begin
         state_q    <= IDLE;
         lane_q     <= '0;
         byte_cnt_q <= '0;
         uflow_q    <= 1'b0;
         done_q     <= 1'b0;
         len_q      <= '0;
         urun_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         done_q     <= fin;
         urun_q     <= 1'b0;
         if (fin) len_q <= cnt_inc;
         if (hs && !in_pad) lane_q <= pop ? '0 : lane_q + LW'(1);
         if (fin) uflow_q <= 1'b0;
         else if (state_q == DATA && !h_valid && byte_cnt_q != 16'd0 && !uflow_q) begin
            uflow_q <= 1'b1;
            urun_q  <= 1'b1;
         end
      end
endmodule

// File: tb/tb_eth_axis_tx_width_conv.sv
// tb_eth_axis_tx_width_conv: scoreboard bench; stimulus pushes expected bytes and frame lengths, a monitor pops them.
module tb_eth_axis_tx_width_conv;
   localparam int S = 4, DEPTH = 4, MINB = 60;
`ifdef ETH_TX_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif
   logic        m_clk_i = 0, s_clk_i = 0, m_rstn_i = 0, s_rstn_i = 0;
   logic [31:0] s_axis_tdata = '0;
   logic [1:0]  s_axis_byte_count = '0;
   logic        s_axis_tvalid = 0, s_axis_tuser = 0, s_axis_tlast = 0, s_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tready = 1;
   logic        frame_done_o, tx_underrun_o;
   logic [15:0] frame_len_o;

   eth_axis_tx_width_conv #(.S_BYTES(S), .FIFO_DEPTH(DEPTH), .MIN_FRAME_BYTES(MINB)) dut (
      .m_clk_i(m_clk_i), .m_rstn_i(m_rstn_i), .s_clk_i(s_clk_i), .s_rstn_i(s_rstn_i),
      .s_axis_tdata(s_axis_tdata), .s_axis_byte_count(s_axis_byte_count),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
      .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .frame_done_o(frame_done_o), .frame_len_o(frame_len_o), .tx_underrun_o(tx_underrun_o)
   );

   always #6 m_clk_i = ~m_clk_i;
   always #2 s_clk_i = ~s_clk_i;

   logic [9:0] exp_q[$];
   int         len_q[$];
   int         n_tests = 0, n_fail = 0;
   int         uflow_cnt = 0, done_cnt = 0, byte_seen = 0, idle_gaps = 0, frame_bytes = 0;
   bit         chk_gap = 0, armed = 0, saw_full = 0, tready_tog = 0, stall = 0;
   logic [10:0] saved;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge m_clk_i) begin
      #1;
      m_axis_tready = tready_tog ? ~m_axis_tready : 1'b1;
   end

   always @(negedge m_clk_i) begin
      if (!m_rstn_i) begin
         stall = 0;
         armed = 0;
      end else begin
         if (stall) check("hold", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, saved);
         if (m_axis_tvalid && m_axis_tready) begin
            byte_seen++;
            if (chk_gap) armed = 1;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL byte: got unexpected %0h, queue empty", m_axis_tdata);
            end else check("byte", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
         end else if (armed && !m_axis_tvalid && exp_q.size() > 0) idle_gaps++;
         stall = m_axis_tvalid && !m_axis_tready;
         saved = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata};
         if (frame_done_o) begin
            done_cnt++;
            if (len_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL frame_len: got unexpected done len %0d", frame_len_o);
            end else check("frame_len", frame_len_o, len_q.pop_front());
         end
         if (tx_underrun_o) uflow_cnt++;
      end
   end

   task automatic send_word(input logic [31:0] d, input logic [1:0] bc, input bit last, input bit user);
      int nb, w;
      nb = last ? int'(bc) + 1 : S;
      for (int i = 0; i < nb; i++) begin
         frame_bytes++;
         exp_q.push_back({user, last && i == nb-1 && !(PAD && frame_bytes < MINB), d[i*8 +: 8]});
      end
      if (last) begin
         if (PAD) for (int p = frame_bytes; p < MINB; p++) exp_q.push_back({1'b0, p == MINB-1, 8'h00});
         len_q.push_back((PAD && frame_bytes < MINB) ? MINB : frame_bytes);
         frame_bytes = 0;
      end
      @(negedge s_clk_i);
      s_axis_tdata = d;
      s_axis_byte_count = bc;
      s_axis_tlast = last;
      s_axis_tuser = user;
      s_axis_tvalid = 1;
      w = 0;
      while (!s_axis_tready && w < 2000) begin
         saw_full = 1;
         w++;
         @(negedge s_clk_i);
      end
      if (w >= 2000) check("write_timeout", 0, 1);
      @(posedge s_clk_i);
      #1 s_axis_tvalid = 0;
   endtask

   task automatic send_frame(input int n, input logic [7:0] base);
      logic [31:0] d;
      for (int w = 0; w < n; w += 4) begin
         for (int k = 0; k < 4; k++) d[k*8 +: 8] = base + 8'(w + k);
         send_word(d, (w + 4 >= n) ? 2'(n - 1 - w) : 2'd0, w + 4 >= n, 1'b0);
      end
   endtask

   task automatic drain;
      int w = 0;
      while ((exp_q.size() > 0 || len_q.size() > 0) && w < 3000) begin
         @(negedge m_clk_i);
         w++;
      end
      check("drain", exp_q.size() + len_q.size(), 0);
      repeat (3) @(negedge m_clk_i);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int w;
      repeat (2) @(negedge m_clk_i);
      check("reset_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata,
                              frame_done_o, frame_len_o, tx_underrun_o}, 0);
      @(posedge m_clk_i);
      #1 m_rstn_i = 1; s_rstn_i = 1;
      repeat (2) @(negedge m_clk_i);
      send_word(32'h44332211, 2'd3, 1'b1, 1'b0);
      drain();
      check("t1_underruns", uflow_cnt, 0);
      tready_tog = 1;
      send_word(32'h04030201, 2'd1, 1'b0, 1'b0);
      send_word(32'h08070605, 2'd1, 1'b0, 1'b1);
      send_word(32'h0C0B0A09, 2'd1, 1'b1, 1'b0);
      drain();
      tready_tog = 0;
      repeat (2) @(negedge m_clk_i);
      send_word(32'h24232221, 2'd0, 1'b0, 1'b0);
      repeat (20) @(posedge m_clk_i);
      send_word(32'h28272625, 2'd3, 1'b1, 1'b0);
      drain();
      check("t3_underruns", uflow_cnt, 1);
      send_frame(14, 8'h30);
      drain();
      send_frame(64, 8'h80);
      drain();
      saw_full = 0;
      chk_gap = 1;
      send_frame(16, 8'h40);
      send_frame(20, 8'h50);
      drain();
      chk_gap = 0;
      check("fifo_full_seen", saw_full, 1);
      check("b2b_idle_gaps", idle_gaps, 0);
      check("underruns_total", uflow_cnt, 1);
      w = byte_seen;
      send_frame(12, 8'h60);
      while (byte_seen < w + 2 && w < 100000) begin
         @(negedge m_clk_i);
         if (byte_seen < w + 2 && $time > 1_900_000) w = 100000;
      end
      @(posedge m_clk_i);
      #1 m_rstn_i = 0; s_rstn_i = 0;
      exp_q.delete();
      len_q.delete();
      frame_bytes = 0;
      repeat (2) begin
         @(negedge m_clk_i);
         check("midframe_reset_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata,
                                          frame_done_o, frame_len_o, tx_underrun_o}, 0);
      end
      @(posedge m_clk_i);
      #1 m_rstn_i = 1; s_rstn_i = 1;
      repeat (2) @(negedge m_clk_i);
      send_frame(6, 8'h70);
      drain();
      check("frames_done", done_cnt, 8);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
